// File: rtl/gray_decoder_pkg.sv
// ============================================================================
// Module      : gray_decoder_pkg
// Description : Shared FSM state type and Gray-to-binary conversion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_decoder_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic [0:0] {
    ST_FIRST = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Callers narrower than GRAY_MAX_W zero-extend; leading zeros leave the result unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_decoder.sv
// ============================================================================
// Module      : gray_decoder
// Description : Gray-to-binary decoder with step classification, error count
//               and a single ready/valid output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_decoder
  import gray_decoder_pkg::*;
#(
  parameter int N    = 4,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  input  logic [N-1:0]    in_gray,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_bin,
  output logic            out_inc,
  output logic            out_wrap,
  output logic            out_err,
  output logic [ERRW-1:0] err_count
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N-1:0]      r_prev_bin;
  logic              r_out_valid;
  logic [N-1:0]      r_out_bin;
  logic              r_out_inc;
  logic              r_out_wrap;
  logic              r_out_err;
  logic [ERRW-1:0]   r_err_count;

  logic              w_accept;
  logic [N-1:0]      w_bin;
  logic [N-1:0]      w_delta;
  logic              w_inc;
  logic              w_wrap;
  logic              w_err;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_bin    = N'(gray_to_bin(GRAY_MAX_W'(in_gray)));
  assign w_delta  = w_bin - r_prev_bin;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_FIRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_inc       = 1'b0;
    w_wrap      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_FIRST: begin
        if (w_accept) begin
          w_state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (w_delta == N'(1)) begin
          w_inc  = 1'b1;
          w_wrap = (r_prev_bin == {N{1'b1}});
        end else if (w_delta != '0) begin
          w_err  = 1'b1;
        end
      end
      default: w_state_nxt = ST_FIRST;
    endcase
  end

  // Every accepted sample resynchronises the tracker, erroneous or not.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prev_bin  <= '0;
      r_out_valid <= 1'b0;
      r_out_bin   <= '0;
      r_out_inc   <= 1'b0;
      r_out_wrap  <= 1'b0;
      r_out_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_prev_bin  <= w_bin;
        r_out_valid <= 1'b1;
        r_out_bin   <= w_bin;
        r_out_inc   <= w_inc;
        r_out_wrap  <= w_wrap;
        r_out_err   <= w_err;
        if (w_err && (r_err_count != {ERRW{1'b1}})) begin
          r_err_count <= r_err_count + ERRW'(1);
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_bin   = r_out_bin;
  assign out_inc   = r_out_inc;
  assign out_wrap  = r_out_wrap;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_gray_decoder.sv
// ============================================================================
// Module      : tb_gray_decoder
// Description : Directed, scoreboard-based self-checking bench for gray_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_decoder;

  localparam int N    = 4;
  localparam int ERRW = 8;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            in_valid = 1'b0;
  logic [N-1:0]    in_gray = '0;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N-1:0]    out_bin;
  logic            out_inc;
  logic            out_wrap;
  logic            out_err;
  logic [ERRW-1:0] err_count;

  gray_decoder #(.N(N), .ERRW(ERRW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_gray   (in_gray),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_inc   (out_inc),
    .out_wrap  (out_wrap),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]    bin;
    logic            inc;
    logic            wrap;
    logic            err;
    logic [ERRW-1:0] cnt;
  } exp_t;

  exp_t         q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic         m_first = 1'b1;
  logic [N-1:0] m_prev = '0;
  int           m_cnt = 0;
  logic [N-1:0] last_bin = '0;
  logic         last_inc = 1'b0;
  logic         last_wrap = 1'b0;
  logic         last_err = 1'b0;
  exp_t         mon_e;
  logic [N-1:0] mon_b;
  logic [N-1:0] mon_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_dec(input logic [N-1:0] g);
    logic [N-1:0] b;
    b = g;
    for (int s = 1; s < N; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Pop/compare the result consumed at the coming edge, then predict the sample accepted there.
  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          check("out_bin",   32'(out_bin),   32'(mon_e.bin));
          check("out_inc",   32'(out_inc),   32'(mon_e.inc));
          check("out_wrap",  32'(out_wrap),  32'(mon_e.wrap));
          check("out_err",   32'(out_err),   32'(mon_e.err));
          check("err_count", 32'(err_count), 32'(mon_e.cnt));
          last_bin  = out_bin;
          last_inc  = out_inc;
          last_wrap = out_wrap;
          last_err  = out_err;
        end
      end
      if (in_valid && in_ready) begin
        mon_b = ref_dec(in_gray);
        mon_e = '0;
        mon_e.bin = mon_b;
        if (!m_first) begin
          mon_d = mon_b - m_prev;
          if (mon_d == N'(1)) begin
            mon_e.inc  = 1'b1;
            mon_e.wrap = (m_prev == {N{1'b1}});
          end else if (mon_d != '0) begin
            mon_e.err = 1'b1;
            if (m_cnt < (1 << ERRW) - 1) m_cnt++;
          end
        end
        m_first   = 1'b0;
        m_prev    = mon_b;
        mon_e.cnt = m_cnt[ERRW-1:0];
        q.push_back(mon_e);
      end
    end
  end

  task automatic send(input logic [N-1:0] g);
    logic ok;
    ok = 1'b0;
    in_gray  = g;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60; t++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    q.delete();
    m_first = 1'b1;
    m_prev  = '0;
    m_cnt   = 0;
    @(negedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2 rstn = 1'b0;
    #1;
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_out_bin",   32'(out_bin),   32'd0);
    check("init_flags",     {29'd0, out_inc, out_wrap, out_err}, 32'd0);
    check("init_err_count", 32'(err_count), 32'd0);
    check("init_in_ready",  32'(in_ready),  32'd1);
    #19 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Incrementing sequence 0,1,2,3
    out_ready = 1'b1;
    send(4'b0000); send(4'b0001); send(4'b0011); send(4'b0010);
    drain();
    check("seq_last_bin", 32'(last_bin), 32'd3);
    check("seq_last_inc", 32'(last_inc), 32'd1);

    // 14 -> 15 -> 0 wrap
    send(4'b1001); send(4'b1000); send(4'b0000);
    drain();
    check("wrap_bin",  32'(last_bin),  32'd0);
    check("wrap_inc",  32'(last_inc),  32'd1);
    check("wrap_flag", 32'(last_wrap), 32'd1);

    // Error then resynchronised increment
    do_reset();
    send(4'b0001); send(4'b0110);
    drain();
    check("err_flag",  32'(last_err),  32'd1);
    check("err_count1", 32'(err_count), 32'd1);
    send(4'b0111);
    drain();
    check("resync_bin", 32'(last_bin), 32'd5);
    check("resync_inc", 32'(last_inc), 32'd1);
    check("resync_err", 32'(last_err), 32'd0);

    // Back-pressure for three cycles
    do_reset();
    send(4'b0000);
    drain();
    out_ready = 1'b0;
    send(4'b0001);
    in_gray  = 4'b0011;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready),  32'd0);
      check("stall_valid",    32'(out_valid), 32'd1);
      check("stall_bin",      32'(out_bin),   32'd1);
      check("stall_inc",      32'(out_inc),   32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("release_valid", 32'(out_valid), 32'd1);
    check("release_bin",   32'(out_bin),   32'd2);
    drain();
    check("release_last_bin", 32'(last_bin), 32'd2);

    // Reset mid-transfer discards the pending result
    out_ready = 1'b0;
    send(4'b0101);
    check("pending_valid", 32'(out_valid), 32'd1);
    do_reset();
    out_ready = 1'b1;
    send(4'b0110);
    drain();
    check("after_rst_bin",   32'(last_bin), 32'd4);
    check("after_rst_flags", {29'd0, last_inc, last_wrap, last_err}, 32'd0);
    check("after_rst_cnt",   32'(err_count), 32'd0);

    // Saturation: 300 errors with ERRW=8
    do_reset();
    send(4'b0000);
    for (int i = 0; i < 300; i++) begin
      send((i % 2 == 0) ? 4'b1100 : 4'b0000);
    end
    drain();
    check("sat_err_count", 32'(err_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
